// File: rtl/expbus_reg_initiator.sv
// Purpose     : initiator (host) end of the expansion-bus register protocol; one bus transaction per accepted request.
// Latency     : write accept -> o_rsp_valid = ADDR_CYCLES + 3 + W (W = target wait after it sees en_z low); reads add one TURN cycle.
// Backpressure: o_req_ready is high only in IDLE; the response is a one-cycle strobe and cannot be stalled.
//
// Ports:
//   i_clk, i_rst_z                 clock and asynchronous active-low reset
//   i_req_* / o_req_ready          request stream (wr, addr, wdata, byte enables)
//   o_rsp_valid/_rdata/_err        one-cycle completion (rdata 0 for writes, err = data-phase timeout)
//   o_reg_* / i_reg_rdy_z          bus strobes (active low), bus reset, target ready
//   i_reg_intr / o_intr_pulse      asynchronous target interrupt, one-cycle pulse per rising edge
//   b_reg_data_I/_O/_T             shared 16-bit address/data pad (T=1 releases the bus)
//
// Build option: define EXPBUS_INIT_TIMEOUT_EN to enable the data-phase timeout (TIMEOUT_CYCLES).
module expbus_reg_initiator #(
   parameter int unsigned ADDR_CYCLES    = 1,
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_z,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wr,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   input  logic [1:0]  i_req_be,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_reg_en_z,
   output logic        o_reg_ads_z,
   output logic        o_reg_uds_z,
   output logic        o_reg_lds_z,
   output logic        o_reg_rd_wr_z,
   output logic        o_reg_reset_z,
   input  logic        i_reg_rdy_z,
   input  logic        i_reg_intr,
   output logic        o_intr_pulse,
   input  logic [15:0] b_reg_data_I,
   output logic [15:0] b_reg_data_O,
   output logic        b_reg_data_T
);

   // Configuration sanity: out-of-range parameters are rejected at elaboration.
   if (ADDR_CYCLES < 1 || ADDR_CYCLES > 15 ||
       RESET_CYCLES < 1 || RESET_CYCLES > 255 ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("expbus_reg_initiator: parameter out of range");
   end

   typedef enum logic [2:0] {
      BUSRST,
      IDLE,
      ADDR,
      TURN,
      DATA,
      DONE,
      RECOVER
   } state_t;

   localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES);
   localparam logic [15:0] ADDR_LAST = 16'(ADDR_CYCLES - 1);
`ifdef EXPBUS_INIT_TIMEOUT_EN
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
`endif

   state_t      state;
   logic [15:0] cnt;        // shared: bus-reset length, address-phase length, data-phase timeout
   logic        req_wr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rdy_q;
   logic [15:0] data_q;
   logic [2:0]  intr_sync;
`ifdef EXPBUS_INIT_TIMEOUT_EN
   logic        rsp_err_q;
`endif

   // Pad inputs registered together so captured read data lines up with rdy_q.
   always_ff @(posedge i_clk or negedge i_rst_z) begin
      if (!i_rst_z) begin
         rdy_q  <= 1'b1;
         data_q <= 16'h0000;
      end else begin
         rdy_q  <= i_reg_rdy_z;
         data_q <= b_reg_data_I;
      end
   end

   // Interrupt: two synchronizer flops, third flop holds the previous level for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_z) begin
      if (!i_rst_z) begin
         intr_sync    <= 3'b000;
         o_intr_pulse <= 1'b0;
      end else begin
         intr_sync    <= {intr_sync[1:0], i_reg_intr};
         o_intr_pulse <= intr_sync[1] & ~intr_sync[2];
      end
   end

   // Transaction FSM; every bus output is registered and changes together with the state.
   always_ff @(posedge i_clk or negedge i_rst_z) begin
      if (!i_rst_z) begin
         state         <= BUSRST;
         cnt           <= 16'h0000;
         req_wr        <= 1'b0;
         req_wdata     <= 16'h0000;
         req_be        <= 2'b00;
         o_req_ready   <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= 16'h0000;
`ifdef EXPBUS_INIT_TIMEOUT_EN
         rsp_err_q     <= 1'b0;
`endif
         o_reg_en_z    <= 1'b1;
         o_reg_ads_z   <= 1'b1;
         o_reg_uds_z   <= 1'b1;
         o_reg_lds_z   <= 1'b1;
         o_reg_rd_wr_z <= 1'b1;
         o_reg_reset_z <= 1'b0;
         b_reg_data_O  <= 16'h0000;
         b_reg_data_T  <= 1'b1;
      end else begin
         o_rsp_valid <= 1'b0;
`ifdef EXPBUS_INIT_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
         case (state)
            BUSRST: begin
               if (cnt == RST_LAST) begin
                  cnt           <= 16'h0000;
                  o_reg_reset_z <= 1'b1;
                  o_req_ready   <= 1'b1;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 16'h0001;
               end
            end

            IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  req_wr       <= i_req_wr;
                  req_wdata    <= i_req_wdata;
                  req_be       <= i_req_be;
                  o_req_ready  <= 1'b0;
                  o_reg_ads_z  <= 1'b0;
                  b_reg_data_T <= 1'b0;
                  b_reg_data_O <= i_req_addr;
                  cnt          <= 16'h0000;
                  state        <= ADDR;
               end
            end

            ADDR: begin
               if (cnt == ADDR_LAST) begin
                  o_reg_ads_z <= 1'b1;
                  cnt         <= 16'h0000;
                  if (req_wr) begin
                     // Writes keep driving the bus straight into the data phase.
                     o_reg_en_z    <= 1'b0;
                     o_reg_uds_z   <= ~req_be[1];
                     o_reg_lds_z   <= ~req_be[0];
                     o_reg_rd_wr_z <= 1'b0;
                     b_reg_data_O  <= req_wdata;
                     state         <= DATA;
                  end else begin
                     // Reads release the bus for one cycle so the target can take it over.
                     b_reg_data_T <= 1'b1;
                     b_reg_data_O <= 16'h0000;
                     state        <= TURN;
                  end
               end else begin
                  cnt <= cnt + 16'h0001;
               end
            end

            TURN: begin
               o_reg_en_z    <= 1'b0;
               o_reg_uds_z   <= ~req_be[1];
               o_reg_lds_z   <= ~req_be[0];
               o_reg_rd_wr_z <= 1'b1;
               cnt           <= 16'h0000;
               state         <= DATA;
            end

            DATA: begin
               // A target ready beats the timeout when both land in the same cycle.
               if (!rdy_q) begin
                  o_reg_en_z    <= 1'b1;
                  o_reg_uds_z   <= 1'b1;
                  o_reg_lds_z   <= 1'b1;
                  o_reg_rd_wr_z <= 1'b1;
                  b_reg_data_T  <= 1'b1;
                  b_reg_data_O  <= 16'h0000;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_rdata   <= req_wr ? 16'h0000 : data_q;
                  state         <= DONE;
`ifdef EXPBUS_INIT_TIMEOUT_EN
               end else if (cnt == TO_LAST) begin
                  o_reg_en_z    <= 1'b1;
                  o_reg_uds_z   <= 1'b1;
                  o_reg_lds_z   <= 1'b1;
                  o_reg_rd_wr_z <= 1'b1;
                  b_reg_data_T  <= 1'b1;
                  b_reg_data_O  <= 16'h0000;
                  o_rsp_valid   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  o_rsp_rdata   <= 16'hDEAD;
                  state         <= DONE;
               end else begin
                  cnt <= cnt + 16'h0001;
`endif
               end
            end

            DONE: begin
`ifdef EXPBUS_INIT_TIMEOUT_EN
               // A timed-out target never drove rdy_z, so there is nothing to wait out.
               if (rsp_err_q) begin
                  o_req_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  state <= RECOVER;
               end
`else
               state <= RECOVER;
`endif
            end

            RECOVER: begin
               if (rdy_q) begin
                  o_req_ready <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= BUSRST;
            end
         endcase
      end
   end

`ifdef EXPBUS_INIT_TIMEOUT_EN
   assign o_rsp_err = rsp_err_q;
`else
   assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_expbus_reg_initiator.sv
// Purpose     : directed self-checking bench for expbus_reg_initiator with an inline target model.
// Latency     : expected latencies are hand-computed from ADDR_CYCLES=1 and the target wait W.
// Backpressure: requests are presented only once o_req_ready is high.
`timescale 1ns/1ps
module tb_expbus_reg_initiator;

   logic        clk = 1'b0;
   logic        i_rst_z = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_wr = 1'b0;
   logic [15:0] i_req_addr = 16'h0000;
   logic [15:0] i_req_wdata = 16'h0000;
   logic [1:0]  i_req_be = 2'b00;
   logic        o_rsp_valid;
   logic [15:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z, o_reg_reset_z;
   logic        i_reg_rdy_z = 1'b1;
   logic        i_reg_intr = 1'b0;
   logic        o_intr_pulse;
   logic [15:0] b_reg_data_I = 16'h0000;
   logic [15:0] b_reg_data_O;
   logic        b_reg_data_T;

   always #5 clk = ~clk;

   expbus_reg_initiator #(
      .ADDR_CYCLES(1),
      .RESET_CYCLES(16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .i_clk(clk),
      .i_rst_z(i_rst_z),
      .i_req_valid(i_req_valid),
      .o_req_ready(o_req_ready),
      .i_req_wr(i_req_wr),
      .i_req_addr(i_req_addr),
      .i_req_wdata(i_req_wdata),
      .i_req_be(i_req_be),
      .o_rsp_valid(o_rsp_valid),
      .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_err(o_rsp_err),
      .o_reg_en_z(o_reg_en_z),
      .o_reg_ads_z(o_reg_ads_z),
      .o_reg_uds_z(o_reg_uds_z),
      .o_reg_lds_z(o_reg_lds_z),
      .o_reg_rd_wr_z(o_reg_rd_wr_z),
      .o_reg_reset_z(o_reg_reset_z),
      .i_reg_rdy_z(i_reg_rdy_z),
      .i_reg_intr(i_reg_intr),
      .o_intr_pulse(o_intr_pulse),
      .b_reg_data_I(b_reg_data_I),
      .b_reg_data_O(b_reg_data_O),
      .b_reg_data_T(b_reg_data_T)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Observations of the most recent transaction.
   int          obs_lat, obs_rsp_cnt, obs_ads_cnt, obs_en_cnt, obs_pulses, obs_ready_gap;
   logic [15:0] obs_rdata, obs_ads_o, obs_data_o;
   logic        obs_err, obs_ads_t, obs_data_t, obs_rdwr, obs_uds, obs_lds, obs_turn, obs_overlap;

   // Drives one request and plays the target: rdy_z goes low once en_z has been seen low w+2 times,
   // i.e. w cycles after the target first samples en_z low. Cycle 0 is the sample after the accept edge.
   task automatic bus_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input int w, input logic [15:0] rdat,
                          input int intr_a, input int intr_b);
      int cyc;
      int guard;
      bit rsp_seen;
      obs_lat = -1; obs_rsp_cnt = 0; obs_ads_cnt = 0; obs_en_cnt = 0; obs_pulses = 0;
      obs_ready_gap = -1; obs_rdata = 16'hxxxx; obs_err = 1'bx; obs_ads_o = 16'hxxxx;
      obs_data_o = 16'hxxxx; obs_ads_t = 1'bx; obs_data_t = 1'bx; obs_rdwr = 1'bx;
      obs_uds = 1'bx; obs_lds = 1'bx; obs_turn = 1'b0; obs_overlap = 1'b0;
      guard = 0;
      @(negedge clk);
      while (o_req_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      i_req_valid = 1'b1; i_req_wr = wr; i_req_addr = addr; i_req_wdata = wdata; i_req_be = be;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      cyc = 0;
      rsp_seen = 1'b0;
      for (int g = 0; g < 400; g++) begin
         if (o_reg_ads_z === 1'b0) begin
            obs_ads_cnt++;
            obs_ads_o = b_reg_data_O;
            obs_ads_t = b_reg_data_T;
            if (o_reg_en_z === 1'b0) obs_overlap = 1'b1;
         end
         if (o_reg_en_z === 1'b0) begin
            obs_en_cnt++;
            obs_data_o = b_reg_data_O; obs_data_t = b_reg_data_T; obs_rdwr = o_reg_rd_wr_z;
            obs_uds = o_reg_uds_z; obs_lds = o_reg_lds_z;
            if (obs_en_cnt == w + 2) begin
               i_reg_rdy_z = 1'b0;
               b_reg_data_I = rdat;
            end
         end
         if (obs_ads_cnt > 0 && obs_en_cnt == 0 && o_reg_ads_z === 1'b1 && o_reg_en_z === 1'b1 &&
             b_reg_data_T === 1'b1 && o_reg_uds_z === 1'b1 && o_reg_lds_z === 1'b1)
            obs_turn = 1'b1;
         if (o_intr_pulse === 1'b1) obs_pulses++;
         if (cyc == intr_a || cyc == intr_b) i_reg_intr = 1'b1;
         else if (cyc == intr_a + 2 || cyc == intr_b + 2) i_reg_intr = 1'b0;
         if (o_rsp_valid === 1'b1) begin
            obs_rsp_cnt++;
            obs_lat = cyc;
            obs_rdata = o_rsp_rdata;
            obs_err = o_rsp_err;
            rsp_seen = 1'b1;
            i_reg_rdy_z = 1'b1;
            b_reg_data_I = 16'h0000;
         end
         if (rsp_seen && o_req_ready === 1'b1) begin
            obs_ready_gap = cyc - obs_lat;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_reg_rdy_z = 1'b1;
      i_reg_intr = 1'b0;
   endtask

   // Releases reset at a falling edge and counts samples with o_reg_reset_z still low.
   task automatic release_reset(output int lowcnt, output bit ready_bad, output int rsp_cnt);
      @(negedge clk);
      i_rst_z = 1'b1;
      lowcnt = 0; ready_bad = 1'b0; rsp_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (o_rsp_valid === 1'b1) rsp_cnt++;
         if (o_reg_reset_z !== 1'b0) break;
         lowcnt++;
         if (o_req_ready !== 1'b0) ready_bad = 1'b1;
      end
   endtask

   task automatic test_reset();
      int  lowcnt;
      bit  rbad;
      int  rsp;
      #23;
      n_chk++; if (o_reg_reset_z !== 1'b0) $display("FAIL rst_reset_z: got %b want 0", o_reg_reset_z); else n_pass++;
      n_chk++; if ({o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z} !== 5'b11111)
         $display("FAIL rst_strobes: got %b want 11111", {o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z}); else n_pass++;
      n_chk++; if ({b_reg_data_T, b_reg_data_O} !== 17'h10000) $display("FAIL rst_pad: got T=%b O=%h want T=1 O=0000", b_reg_data_T, b_reg_data_O); else n_pass++;
      n_chk++; if ({o_req_ready, o_rsp_valid, o_rsp_err, o_intr_pulse} !== 4'b0000)
         $display("FAIL rst_flags: got %b want 0000", {o_req_ready, o_rsp_valid, o_rsp_err, o_intr_pulse}); else n_pass++;
      n_chk++; if (o_rsp_rdata !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", o_rsp_rdata); else n_pass++;
      release_reset(lowcnt, rbad, rsp);
      n_chk++; if (lowcnt !== 16) $display("FAIL busrst_len: got %0d want 16", lowcnt); else n_pass++;
      n_chk++; if (rbad !== 1'b0) $display("FAIL busrst_ready: ready rose during bus reset"); else n_pass++;
      n_chk++; if (o_req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", o_req_ready); else n_pass++;
      n_chk++; if ({o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z, b_reg_data_T} !== 6'b111111)
         $display("FAIL idle_strobes: got %b want 111111", {o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z, b_reg_data_T}); else n_pass++;
   endtask

   task automatic test_write();
      bus_txn(1'b1, 16'h0010, 16'hA55A, 2'b11, 2, 16'h0000, -1, -1);
      n_chk++; if (obs_ads_cnt !== 1) $display("FAIL wr_ads_len: got %0d want 1", obs_ads_cnt); else n_pass++;
      n_chk++; if ({obs_ads_t, obs_ads_o} !== {1'b0, 16'h0010}) $display("FAIL wr_addr: got T=%b O=%h want T=0 O=0010", obs_ads_t, obs_ads_o); else n_pass++;
      n_chk++; if ({obs_data_t, obs_data_o} !== {1'b0, 16'hA55A}) $display("FAIL wr_data: got T=%b O=%h want T=0 O=a55a", obs_data_t, obs_data_o); else n_pass++;
      n_chk++; if ({obs_rdwr, obs_uds, obs_lds} !== 3'b000) $display("FAIL wr_strobes: got %b want 000", {obs_rdwr, obs_uds, obs_lds}); else n_pass++;
      n_chk++; if (obs_turn !== 1'b0) $display("FAIL wr_no_turn: got %b want 0", obs_turn); else n_pass++;
      n_chk++; if (obs_en_cnt !== 5) $display("FAIL wr_en_len: got %0d want 5", obs_en_cnt); else n_pass++;
      n_chk++; if (obs_lat !== 6) $display("FAIL wr_latency: got %0d want 6", obs_lat); else n_pass++;
      n_chk++; if (obs_rsp_cnt !== 1) $display("FAIL wr_rsp_count: got %0d want 1", obs_rsp_cnt); else n_pass++;
      n_chk++; if ({obs_err, obs_rdata} !== 17'h00000) $display("FAIL wr_rsp: got err=%b rdata=%h want 0/0000", obs_err, obs_rdata); else n_pass++;
      n_chk++; if (obs_ready_gap !== 2) $display("FAIL wr_recover: got %0d want 2", obs_ready_gap); else n_pass++;
   endtask

   task automatic test_read();
      bus_txn(1'b0, 16'h0004, 16'hFFFF, 2'b01, 1, 16'h1234, -1, -1);
      n_chk++; if (obs_ads_o !== 16'h0004) $display("FAIL rd_addr: got %h want 0004", obs_ads_o); else n_pass++;
      n_chk++; if (obs_turn !== 1'b1) $display("FAIL rd_turn: got %b want 1", obs_turn); else n_pass++;
      n_chk++; if ({obs_uds, obs_lds, obs_rdwr, obs_data_t} !== 4'b1011) $display("FAIL rd_strobes: got %b want 1011", {obs_uds, obs_lds, obs_rdwr, obs_data_t}); else n_pass++;
      n_chk++; if (obs_lat !== 6) $display("FAIL rd_latency: got %0d want 6", obs_lat); else n_pass++;
      n_chk++; if ({obs_err, obs_rdata} !== {1'b0, 16'h1234}) $display("FAIL rd_rsp: got err=%b rdata=%h want 0/1234", obs_err, obs_rdata); else n_pass++;
      n_chk++; if (obs_overlap !== 1'b0) $display("FAIL rd_overlap: got %b want 0", obs_overlap); else n_pass++;
   endtask

   task automatic test_be_zero();
      bus_txn(1'b1, 16'h0030, 16'h5A5A, 2'b00, 0, 16'h0000, -1, -1);
      n_chk++; if ({obs_uds, obs_lds} !== 2'b11) $display("FAIL be0_strobes: got %b want 11", {obs_uds, obs_lds}); else n_pass++;
      n_chk++; if (obs_en_cnt !== 3) $display("FAIL be0_en_len: got %0d want 3", obs_en_cnt); else n_pass++;
      n_chk++; if (obs_lat !== 4) $display("FAIL be0_latency: got %0d want 4", obs_lat); else n_pass++;
      n_chk++; if (obs_rsp_cnt !== 1) $display("FAIL be0_rsp_count: got %0d want 1", obs_rsp_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus_txn(1'b0, 16'h0100, 16'h0000, 2'b10, 0, 16'hC0DE, -1, -1);
      n_chk++; if ({obs_lat, obs_ready_gap} !== {32'd5, 32'd2}) $display("FAIL b2b_rd_timing: got lat=%0d gap=%0d want 5/2", obs_lat, obs_ready_gap); else n_pass++;
      n_chk++; if (obs_rdata !== 16'hC0DE) $display("FAIL b2b_rd_data: got %h want c0de", obs_rdata); else n_pass++;
      bus_txn(1'b1, 16'h0102, 16'h0F0F, 2'b10, 0, 16'h0000, -1, -1);
      n_chk++; if ({obs_ads_o, obs_data_o} !== {16'h0102, 16'h0F0F}) $display("FAIL b2b_wr_bus: got addr=%h data=%h want 0102/0f0f", obs_ads_o, obs_data_o); else n_pass++;
      n_chk++; if ({obs_uds, obs_lds, obs_overlap} !== 3'b010) $display("FAIL b2b_wr_strobes: got %b want 010", {obs_uds, obs_lds, obs_overlap}); else n_pass++;
      n_chk++; if (obs_lat !== 4) $display("FAIL b2b_wr_latency: got %0d want 4", obs_lat); else n_pass++;
   endtask

`ifdef EXPBUS_INIT_TIMEOUT_EN
   task automatic test_timeout();
      bus_txn(1'b1, 16'h0040, 16'h1111, 2'b11, 1000, 16'h0000, -1, -1);
      n_chk++; if (obs_en_cnt !== 8) $display("FAIL to_data_len: got %0d want 8", obs_en_cnt); else n_pass++;
      n_chk++; if (obs_lat !== 9) $display("FAIL to_latency: got %0d want 9", obs_lat); else n_pass++;
      n_chk++; if ({obs_err, obs_rdata} !== {1'b1, 16'hDEAD}) $display("FAIL to_rsp: got err=%b rdata=%h want 1/dead", obs_err, obs_rdata); else n_pass++;
      n_chk++; if (obs_ready_gap !== 1) $display("FAIL to_skip_recover: got %0d want 1", obs_ready_gap); else n_pass++;
      bus_txn(1'b1, 16'h0042, 16'h2222, 2'b11, 0, 16'h0000, -1, -1);
      n_chk++; if ({obs_rsp_cnt, obs_lat} !== {32'd1, 32'd4}) $display("FAIL to_next_req: got cnt=%0d lat=%0d want 1/4", obs_rsp_cnt, obs_lat); else n_pass++;
      n_chk++; if (obs_err !== 1'b0) $display("FAIL to_next_err: got %b want 0", obs_err); else n_pass++;
   endtask
`else
   task automatic test_no_timeout();
      bus_txn(1'b1, 16'h0040, 16'h1111, 2'b11, 30, 16'h0000, -1, -1);
      n_chk++; if (obs_en_cnt !== 33) $display("FAIL hold_data_len: got %0d want 33", obs_en_cnt); else n_pass++;
      n_chk++; if (obs_lat !== 34) $display("FAIL hold_latency: got %0d want 34", obs_lat); else n_pass++;
      n_chk++; if (obs_err !== 1'b0) $display("FAIL hold_err: got %b want 0", obs_err); else n_pass++;
   endtask
`endif

   task automatic test_intr_during_read();
      bus_txn(1'b0, 16'h0008, 16'h0000, 2'b11, 12, 16'hBEEF, 3, 8);
      n_chk++; if (obs_pulses !== 2) $display("FAIL intr_pulses: got %0d want 2", obs_pulses); else n_pass++;
      n_chk++; if (obs_lat !== 17) $display("FAIL intr_rd_latency: got %0d want 17", obs_lat); else n_pass++;
      n_chk++; if ({obs_err, obs_rdata} !== {1'b0, 16'hBEEF}) $display("FAIL intr_rd_data: got err=%b rdata=%h want 0/beef", obs_err, obs_rdata); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lowcnt;
      bit rbad;
      int rsp;
      int guard;
      guard = 0;
      @(negedge clk);
      while (o_req_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 16'h0020; i_req_wdata = 16'hBEEF; i_req_be = 2'b11;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      for (int g = 0; g < 20; g++) begin
         if (o_reg_en_z === 1'b0) break;
         @(posedge clk); #1;
      end
      n_chk++; if (o_reg_en_z !== 1'b0) $display("FAIL mid_en_low: got %b want 0", o_reg_en_z); else n_pass++;
      #2 i_rst_z = 1'b0;
      #1;
      n_chk++; if ({o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z, b_reg_data_T} !== 6'b111111)
         $display("FAIL mid_strobes: got %b want 111111", {o_reg_en_z, o_reg_ads_z, o_reg_uds_z, o_reg_lds_z, o_reg_rd_wr_z, b_reg_data_T}); else n_pass++;
      n_chk++; if ({o_reg_reset_z, o_req_ready, o_rsp_valid} !== 3'b000) $display("FAIL mid_flags: got %b want 000", {o_reg_reset_z, o_req_ready, o_rsp_valid}); else n_pass++;
      repeat (3) @(posedge clk);
      release_reset(lowcnt, rbad, rsp);
      n_chk++; if (lowcnt !== 16) $display("FAIL mid_busrst_len: got %0d want 16", lowcnt); else n_pass++;
      n_chk++; if ({rbad, rsp} !== {1'b0, 32'd0}) $display("FAIL mid_no_rsp: got ready_bad=%b rsp=%0d want 0/0", rbad, rsp); else n_pass++;
      bus_txn(1'b0, 16'h0006, 16'h0000, 2'b11, 0, 16'h7E57, -1, -1);
      n_chk++; if ({obs_rsp_cnt, obs_rdata} !== {32'd1, 16'h7E57}) $display("FAIL mid_after_read: got cnt=%0d rdata=%h want 1/7e57", obs_rsp_cnt, obs_rdata); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_be_zero();
      test_back_to_back();
`ifdef EXPBUS_INIT_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_intr_during_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
